dmem_responder: RTL

// Data-memory responder: the target side of the load/store request interface driven by the MEM stage.
// - Accepts one request at a time over a valid/ready handshake.
// - Models WAIT_CYCLES of access latency, then performs the word read or write on an internal array.
// - Returns the result over a valid/ready response channel.
// - Sits between the MEM stage and storage, so the pipeline can be exercised against a multi-cycle memory.
//

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: the target side of the MEM-stage load/store interface, backed by a 2**ADDR_W x 16 array.
// Latency: a request accepted in cycle 0 presents its response from cycle WAIT_CYCLES+1 and holds it until accepted.
// Backpressure: one transaction at a time. req_ready drops while busy. The response is held stable while resp_ready=0.
//
// Ports:
//   CLOCK_50                  system clock (rising edge)
//   reset                     asynchronous, active-high reset
//   req_valid/req_ready       request handshake; req_we=1 store, 0 load
//   req_addr/req_wdata        word address and store data, captured on accept
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_err       load data (or store echo) and out-of-range flag
//   busy                      a transaction is in flight
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_err;

    // Storage is deliberately outside the reset domain: contents survive reset.
    logic [15:0] r_mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_do_access;
    logic              w_acc_we;
    logic [15:0]       w_acc_addr;
    logic [15:0]       w_acc_wdata;
    logic [ADDR_W-1:0] w_acc_idx;
    logic              w_oor;

    // req_ready is masked by reset so no request is taken while reset is held.
    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept = req_valid && req_ready;

    // With zero wait the access happens at the accept edge itself, so it must
    // use the live request fields rather than the (not yet loaded) captures.
    assign w_do_access = ZERO_WAIT ? ((r_state == S_IDLE) && w_accept)
                                   : ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_acc_we    = ZERO_WAIT ? req_we    : r_we;
    assign w_acc_addr  = ZERO_WAIT ? req_addr  : r_addr;
    assign w_acc_wdata = ZERO_WAIT ? req_wdata : r_wdata;
    assign w_acc_idx   = w_acc_addr[ADDR_W-1:0];

    // Any set bit above the array's index range makes the address invalid.
    assign w_oor = ((w_acc_addr >> ADDR_W) != 16'd0);

    always_ff @(posedge CLOCK_50) begin
        if (w_do_access && w_acc_we && !w_oor) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            // Response data is registered at the access edge; it then stays
            // put through RESP and keeps its value after the handshake.
            if (w_do_access) begin
                r_err <= w_oor;
                if (w_oor) begin
                    r_rdata <= 16'd0;
                end else if (w_acc_we) begin
                    r_rdata <= w_acc_wdata;
                end else begin
                    r_rdata <= r_mem[w_acc_idx];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (ZERO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // Returning through IDLE guarantees a new request is never
                    // taken on the same edge as the response handshake.
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
